// File: rtl/uart_phy_pkg.sv
// Shared frame constants and FSM state encodings for the UART serial-line PHY.
package uart_defs;
  localparam int DATA_BITS = 8;
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_phy_if.sv
// 8250-side strobes plus the board TX/RX pins; master = 8250/board side, slave = PHY.
interface uart_phy_if;
  import uart_defs::*;

  logic [DATA_BITS-1:0] iTxData;
  logic                 iTx;
  logic                 oTxReady;
  logic                 oSerTx;
  logic                 iSerRx;
  logic [DATA_BITS-1:0] oRxData;
  logic                 oRx;
  logic                 iRxReady;
  logic                 iRxTaken;
  logic                 oFrameErr;
  logic                 oOverrun;

  modport master (
    output iTxData, iTx, iSerRx, iRxReady, iRxTaken,
    input  oTxReady, oSerTx, oRxData, oRx, oFrameErr, oOverrun
  );

  modport slave (
    input  iTxData, iTx, iSerRx, iRxReady, iRxTaken,
    output oTxReady, oSerTx, oRxData, oRx, oFrameErr, oOverrun
  );
endinterface

// File: rtl/uart_phy_tx.sv
// 8N1 serialiser: byte accepted in IDLE, start bit on the pin next cycle, 10*CLK_DIV cycle frame.
// Strobes arriving while busy (tx_rdy_o low) are dropped.
module uart_phy_tx
  import uart_defs::*;
#(
  parameter int CLK_DIV   = 260,
  parameter int CLK_DIV_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_dat_i,
  input  logic                 tx_vld_i,
  output logic                 tx_rdy_o,
  output logic                 ser_tx_o
);
  localparam logic [CLK_DIV_W-1:0] CNT_LAST = CLK_DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CLK_DIV_W-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_q, bit_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CLK_DIV_W'(1);
    shift_d  = shift_q;
    bit_d    = bit_q;
    tx_rdy_o = 1'b0;
    ser_tx_o = STOP_LVL;
    case (state_q)
      TX_IDLE: begin
        tx_rdy_o = 1'b1;
        cnt_d    = '0;
        if (tx_vld_i) begin
          shift_d = tx_dat_i;
          state_d = TX_START;
        end
      end
      TX_START: begin
        ser_tx_o = START_LVL;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        ser_tx_o = shift_q[0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = TX_STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_phy.sv
// UART PHY between the 8250 register model and the pins: TX serialiser plus RX deserialiser
// with a one-byte pending buffer; delivery honours iRxReady, overflow pulses oOverrun.
module uart_phy
  import uart_defs::*;
#(
  parameter int CLK_DIV   = 260,
  parameter int CLK_DIV_W = 16
) (
  input  logic      iClk,
  input  logic      iRst,
  uart_phy_if.slave bus
);
  localparam logic [CLK_DIV_W-1:0] CNT_LAST = CLK_DIV_W'(CLK_DIV - 1);
  localparam logic [CLK_DIV_W-1:0] CNT_HALF = CLK_DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_phy_tx #(.CLK_DIV(CLK_DIV), .CLK_DIV_W(CLK_DIV_W)) u_tx (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .tx_dat_i (bus.iTxData),
    .tx_vld_i (bus.iTx),
    .tx_rdy_o (bus.oTxReady),
    .ser_tx_o (bus.oSerTx)
  );

  logic unused_rx_taken;
  assign unused_rx_taken = bus.iRxTaken;

  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CLK_DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic                 byte_done, frame_err;
  logic                 rx_vld_q, rx_vld_d;
  logic [DATA_BITS-1:0] rx_dat_q, rx_dat_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [DATA_BITS-1:0] pend_dat_q, pend_dat_d;
  logic                 ferr_q, ovr_q, ovr_d;
  logic                 can_send;

  assign rx_s = sync_q[1];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_vld_q   <= 1'b0;
      rx_dat_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.iSerRx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_vld_q   <= rx_vld_d;
      rx_dat_q   <= rx_dat_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      ferr_q     <= frame_err;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CLK_DIV_W'(1);
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = (rx_s == START_LVL) ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s == STOP_LVL) begin
            byte_done  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // The 8250 lowers its ready one cycle after oRx, so ready is ignored while oRx is high.
  assign can_send = bus.iRxReady && !rx_vld_q;

  always_comb begin
    rx_vld_d   = 1'b0;
    rx_dat_d   = rx_dat_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    ovr_d      = 1'b0;
    if (pend_vld_q && can_send) begin
      rx_vld_d   = 1'b1;
      rx_dat_d   = pend_dat_q;
      pend_vld_d = 1'b0;
    end
    if (byte_done) begin
      if (!pend_vld_q && can_send) begin
        rx_vld_d = 1'b1;
        rx_dat_d = rx_sh_q;
      end else if (!pend_vld_d) begin
        pend_vld_d = 1'b1;
        pend_dat_d = rx_sh_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.oRx       = rx_vld_q;
  assign bus.oRxData   = rx_dat_q;
  assign bus.oFrameErr = ferr_q;
  assign bus.oOverrun  = ovr_q;
endmodule

// File: tb/tb_uart_phy.sv
// Bench for uart_phy at CLK_DIV=16: frame-level TX waveform model and a one-slot RX delivery model.
module tb_uart_phy;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_phy_if bus();

  uart_phy #(.CLK_DIV(DIV), .CLK_DIV_W(8)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         rx_cnt  = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  int         dbl_cnt = 0;
  logic       prev_rx = 1'b0;
  logic [7:0] rx_log [256];
  int         rx_at  [256];

  int         want_n  = 0;
  int         want_fe = 0;
  int         want_ov = 0;
  int         chk_n   = 0;
  logic [7:0] want_log [256];
  logic [7:0] mdl_buf [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.oRx === 1'b1) begin
      if (rx_cnt < 256) begin
        rx_log[rx_cnt] = bus.oRxData;
        rx_at[rx_cnt]  = cyc;
      end
      rx_cnt++;
      if (prev_rx) dbl_cnt++;
    end
    prev_rx = (bus.oRx === 1'b1);
    if (bus.oFrameErr === 1'b1) fe_cnt++;
    if (bus.oOverrun === 1'b1)  ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Receiver model: one-slot buffer, direct delivery only when ready and the slot is empty.
  task automatic mdl_rx(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                                      want_fe++;
    else if (bus.iRxReady && mdl_buf.size() == 0) begin
      want_log[want_n] = b;
      want_n++;
    end else if (mdl_buf.size() == 0)                  mdl_buf.push_back(b);
    else                                               want_ov++;
  endtask

  task automatic mdl_ready();
    if (bus.iRxReady && mdl_buf.size() != 0) begin
      want_log[want_n] = mdl_buf.pop_front();
      want_n++;
    end
  endtask

  task automatic verify_rx(input string tag);
    check({tag, "_rx_count"}, rx_cnt, want_n);
    check({tag, "_frame_err_count"}, fe_cnt, want_fe);
    check({tag, "_overrun_count"}, ov_cnt, want_ov);
    for (int i = chk_n; i < want_n && i < rx_cnt; i++)
      check({tag, "_rx_data"}, rx_log[i], want_log[i]);
    chk_n = want_n;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_lvl);
    logic [9:0] fr;
    fr = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.iSerRx = fr[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit poke);
    logic [9:0] fr;
    int         t;
    int         errs;
    fr   = {1'b1, b, 1'b0};
    t    = 0;
    errs = 0;
    while (bus.oTxReady !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_before_send", bus.oTxReady, 1'b1);
    bus.iTxData = b;
    bus.iTx     = 1'b1;
    @(negedge clk);
    bus.iTx = 1'b0;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (k == 0) check("tx_ready_drops", bus.oTxReady, 1'b0);
      if (bus.oSerTx !== fr[k / DIV] || bus.oTxReady !== 1'b0) errs++;
      if (k % DIV == DIV / 2) check("tx_bit_level", bus.oSerTx, fr[k / DIV]);
      if (poke && k == 20) begin
        bus.iTxData = 8'h3C;
        bus.iTx     = 1'b1;
      end else begin
        bus.iTx = 1'b0;
      end
      @(negedge clk);
    end
    check("tx_waveform_errors", errs, 0);
    check("tx_ready_returns", bus.oTxReady, 1'b1);
  endtask

  initial begin
    int         lat;
    int         r0;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [9:0] rf;

    bus.iTxData  = 8'h00;
    bus.iTx      = 1'b0;
    bus.iSerRx   = 1'b1;
    bus.iRxReady = 1'b1;
    bus.iRxTaken = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ser_tx", bus.oSerTx, 1'b1);
    check("reset_tx_ready", bus.oTxReady, 1'b1);
    check("reset_rx", bus.oRx, 1'b0);
    check("reset_rx_data", bus.oRxData, 8'h00);
    check("reset_frame_err", bus.oFrameErr, 1'b0);
    check("reset_overrun", bus.oOverrun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    tx_frame(8'hA5, 1'b0);
    tx_frame(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'b0);

    r0 = rx_cnt;
    lat = cyc;
    rx_send(8'h5A, 1'b1);
    mdl_rx(8'h5A, 1'b1);
    repeat (8) @(negedge clk);
    verify_rx("rx_5a");
    lat = (rx_cnt > r0) ? rx_at[r0] - lat : -1;
    check("rx_latency_in_window", 32'(lat >= 150 && lat <= 160), 1);

    for (int i = 0; i < 4; i++) begin
      b0 = 8'($urandom);
      rx_send(b0, 1'b1);
      mdl_rx(b0, 1'b1);
      bus.iSerRx = 1'b1;
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    verify_rx("rx_random");

    bus.iRxReady = 1'b0;
    b0 = 8'h11;
    b1 = 8'h22;
    rx_send(b0, 1'b1);
    mdl_rx(b0, 1'b1);
    rx_send(b1, 1'b1);
    mdl_rx(b1, 1'b1);
    repeat (8) @(negedge clk);
    verify_rx("flow_held");
    bus.iRxReady = 1'b1;
    mdl_ready();
    repeat (6) @(negedge clk);
    verify_rx("flow_release");
    repeat (200) @(negedge clk);
    verify_rx("flow_settled");

    rx_send(8'h00, 1'b0);
    mdl_rx(8'h00, 1'b0);
    repeat (8) @(negedge clk);
    verify_rx("frame_err");
    repeat (40 * DIV) @(negedge clk);
    bus.iSerRx = 1'b1;
    repeat (40) @(negedge clk);
    verify_rx("break");
    bus.iSerRx = 1'b0;
    repeat (4) @(negedge clk);
    bus.iSerRx = 1'b1;
    repeat (40) @(negedge clk);
    verify_rx("glitch");

    b0 = 8'($urandom);
    b1 = 8'($urandom);
    fork
      tx_frame(b0, 1'b0);
      begin
        rx_send(b1, 1'b1);
        bus.iSerRx = 1'b1;
      end
    join
    mdl_rx(b1, 1'b1);
    repeat (8) @(negedge clk);
    verify_rx("concurrent");

    // Reset lands in TX data bit 3 and RX data bit 5.
    rf = {1'b1, 8'($urandom), 1'b0};
    for (int c = 0; c < 103; c++) begin
      bus.iSerRx = rf[c / DIV];
      if (c == 32) begin
        bus.iTxData = 8'($urandom);
        bus.iTx     = 1'b1;
      end else begin
        bus.iTx = 1'b0;
      end
      @(negedge clk);
    end
    rst        = 1'b1;
    bus.iSerRx = 1'b1;
    @(negedge clk);
    check("midreset_ser_tx", bus.oSerTx, 1'b1);
    check("midreset_tx_ready", bus.oTxReady, 1'b1);
    check("midreset_rx", bus.oRx, 1'b0);
    rst = 1'b0;
    mdl_buf.delete();
    repeat (250) @(negedge clk);
    verify_rx("midreset_quiet");
    fork
      tx_frame(8'h7E, 1'b0);
      begin
        rx_send(8'h7E, 1'b1);
        bus.iSerRx = 1'b1;
      end
    join
    mdl_rx(8'h7E, 1'b1);
    repeat (8) @(negedge clk);
    verify_rx("after_reset");

    check("rx_no_back_to_back", dbl_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
